e_muldiv_unit: RTL and testbench
================================

// Module: e_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the execute stage, fed directly from
//  the decode/execute pipeline register outputs (operand1/operand2/rd).
//  Shift-add multiply and restoring divide, one bit per cycle.
//  Raises stall_req so that register and everything upstream hold while it computes.
//  Presents result/rd for the execute/memory stage on a one-cycle done pulse.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk        in   1     clock, rising edge
//  nrst       in   1     reset, asynchronous, active-low
//  start      in   1     muldiv instruction present in execute (level, held during stall)
//  op         in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  operand1   in   XLEN  rs1 value (multiplicand / dividend)
//  operand2   in   XLEN  rs2 value (multiplier / divisor)
//  rd         in   5     destination register
//  flush      in   1     kill in-flight op (branch redirect / trap)
//  busy       out  1     state != IDLE
//  stall_req  out  1     hold decode/execute register and upstream stages
//  done       out  1     one-cycle pulse: result/rd_out valid
//  result     out  XLEN  computed value
//  rd_out     out  5     rd latched at start
// BEHAVIOUR
//  - Reset (nrst low, async): state=IDLE, busy=0, done=0, result=0, rd_out=0, internal regs 0;
//    stall_req forced 0 while nrst low. Mid-operation reset aborts without done.
//  - FSM IDLE->CALC->DONE->IDLE.
//    IDLE: start=1 samples op/operands/rd at edge T0 (cycle 0) -> CALC.
//    CALC: XLEN cycles (1..XLEN), counter XLEN-1 down to 0; at 0 -> DONE.
//    DONE: cycle XLEN+1, done=1, result final; -> IDLE unconditionally.
//  - start is sampled only in IDLE; ignored in CALC and DONE (same instruction still held).
//  - stall_req = (IDLE & start & ~flush) | CALC; 0 in DONE so the pipe advances that cycle.
//  - Multiply: |a|*|b| on magnitudes to 2*XLEN product, negated if signs differ.
//    MUL low XLEN; MULH s*s high; MULHSU s(op1)*u(op2) high; MULHU u*u high.
//  - Divide: restoring on magnitudes; quotient negated if signed and signs differ;
//    remainder takes dividend sign.
//  - Divisor 0: DIV/DIVU = all ones; REM/REMU = operand1.
//    Signed overflow (-2^(XLEN-1) / -1): DIV = -2^(XLEN-1), REM = 0. No exceptions.
//  - result/rd_out update only at DONE entry; held until next DONE.
//  - flush (sync): any state -> IDLE next edge; no done, result unchanged.
//    flush with start in IDLE: start not accepted. Flush in DONE: done still pulses (already retiring).
// CONFIGURATION
//  MULDIV_SPECIAL_FAST_EN defined: divisor 0, signed overflow, or any zero multiply operand
//    go IDLE->DONE directly; done in cycle 1, stall_req high cycle 0 only.
//  Undefined: all ops take full XLEN+2 cycles; special-case results identical (fixed at DONE).
// TESTING
//  MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, rd_out=rd; stall_req cycles 0..32, done at cycle 33 only.
//  MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE; MULH 0x80000000^2 -> 0x40000000; MULHSU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -20/3 -> 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0;
//    done at cycle 33 without macro, cycle 1 with MULDIV_SPECIAL_FAST_EN.
//  flush at CALC cycle 10 -> IDLE next cycle, no done, result keeps prior value;
//    next start accepted immediately.
//  nrst low at CALC cycle 5 -> all outputs 0 without clock edge; start held through DONE
//    -> exactly one done per instruction.

Source files
------------

// File: rtl/e_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_SPECIAL_FAST_EN: trivial cases (divide by zero, signed overflow, zero multiply operand) skip CALC.
module e_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_operand1,
  input  logic [XLEN-1:0] i_operand2,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_stall_req,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_out
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic [4:0]      r_rd;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_special;
  logic [XLEN-1:0] r_special_res;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_out;

  // Operand decode at issue
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_fast;

  assign w_is_div   = i_op[2];
  assign w_a_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
  assign w_b_signed = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
  assign w_a_neg    = w_a_signed & i_operand1[XLEN-1];
  assign w_b_neg    = w_b_signed & i_operand2[XLEN-1];
  assign w_a_mag    = w_a_neg ? -i_operand1 : i_operand1;
  assign w_b_mag    = w_b_neg ? -i_operand2 : i_operand2;
  assign w_div0     = (i_operand2 == '0);
  assign w_ovf      = ((i_op == OP_DIV) || (i_op == OP_REM)) && (i_operand1 == MIN_NEG) && (i_operand2 == '1);
  assign w_special  = w_is_div & (w_div0 | w_ovf);

  // op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    w_special_res = '0;
    if (w_is_div && w_div0) begin
      w_special_res = i_op[1] ? i_operand1 : '1;
    end else if (w_ovf) begin
      w_special_res = i_op[1] ? '0 : MIN_NEG;
    end
  end

`ifdef MULDIV_SPECIAL_FAST_EN
  logic w_mul_zero;
  assign w_mul_zero = ~w_is_div & ((i_operand1 == '0) | (i_operand2 == '0));
  assign w_fast     = w_special | w_mul_zero;
`else
  assign w_fast     = 1'b0;
`endif

  // One iteration step; r_hi:r_lo is product (mul) or remainder:quotient (div)
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_shift;
  logic [XLEN:0]   w_div_diff;
  logic [XLEN-1:0] w_hi_next;
  logic [XLEN-1:0] w_lo_next;

  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};

  always_comb begin
    w_hi_next = r_hi;
    w_lo_next = r_lo;
    if (r_op[2]) begin
      if (!w_div_diff[XLEN]) begin
        w_hi_next = w_div_diff[XLEN-1:0];
        w_lo_next = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_next = w_div_shift[XLEN-1:0];
        w_lo_next = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_next = w_mul_sum[XLEN:1];
      w_lo_next = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Sign fix-up applied to the value produced by the final iteration
  logic [2*XLEN-1:0] w_prod_mag;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_prod_mag = {w_hi_next, w_lo_next};
  assign w_prod     = r_neg_q ? -w_prod_mag : w_prod_mag;
  assign w_quot     = r_neg_q ? -w_lo_next : w_lo_next;
  assign w_rem      = r_neg_r ? -w_hi_next : w_hi_next;

  always_comb begin
    w_final = '0;
    case (r_op)
      OP_MUL:                      w_final = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             w_final = r_special ? r_special_res : w_quot;
      OP_REM, OP_REMU:             w_final = r_special ? r_special_res : w_rem;
      default:                     w_final = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_rd          <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_special     <= 1'b0;
      r_special_res <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_b           <= '0;
      r_cnt         <= '0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_rd_out      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start && !i_flush) begin
            r_op          <= i_op;
            r_rd          <= i_rd;
            r_neg_q       <= w_a_neg ^ w_b_neg;
            r_neg_r       <= w_a_neg;
            r_special     <= w_special;
            r_special_res <= w_special_res;
            r_hi          <= '0;
            r_lo          <= w_is_div ? w_a_mag : w_b_mag;
            r_b           <= w_is_div ? w_b_mag : w_a_mag;
            r_cnt         <= CW'(XLEN-1);
            if (w_fast) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_special_res;
              r_rd_out <= i_rd;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else begin
            r_hi <= w_hi_next;
            r_lo <= w_lo_next;
            if (r_cnt == '0) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_final;
              r_rd_out <= r_rd;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_DONE: begin
          // Already retiring: a flush here cannot cancel the pulse
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_stall_req = i_nrst & (((r_state == S_IDLE) & i_start & ~i_flush) | (r_state == S_CALC));
  assign o_done      = r_done;
  assign o_result    = r_result;
  assign o_rd_out    = r_rd_out;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Directed + scoreboard bench for e_muldiv_unit; latency expectations follow MULDIV_SPECIAL_FAST_EN.
module tb_e_muldiv_unit;
  localparam int XLEN = 32;

`ifdef MULDIV_SPECIAL_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_nrst;
  logic            i_start;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_operand1;
  logic [XLEN-1:0] i_operand2;
  logic [4:0]      i_rd;
  logic            i_flush;
  logic            o_busy;
  logic            o_stall_req;
  logic            o_done;
  logic [XLEN-1:0] o_result;
  logic [4:0]      o_rd_out;

  int total = 0;
  int bad   = 0;
  logic [36:0] sb_q[$];

  always #5 i_clk = ~i_clk;

  e_muldiv_unit #(.XLEN(XLEN)) dut (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_operand1 (i_operand1),
    .i_operand2 (i_operand2),
    .i_rd       (i_rd),
    .i_flush    (i_flush),
    .o_busy     (o_busy),
    .o_stall_req(o_stall_req),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_rd_out   (o_rd_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] mn;
    mn = 32'h8000_0000;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == mn && b == 32'hFFFF_FFFF) return mn;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == mn && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit special;
    if (op[2]) special = (b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else       special = (a == 0) || (b == 0);
    return (FAST && special) ? 1 : XLEN + 1;
  endfunction

  // Called just after a falling edge; returns just after the falling edge following DONE
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res);
    int cyc;
    bit got;
    bit stall_ok;
    logic [36:0] e;
    sb_q.push_back({rd, exp_res});
    i_op = op; i_operand1 = a; i_operand2 = b; i_rd = rd; i_start = 1'b1;
    #1;
    chk({tag, ".stall_c0"}, o_stall_req, 1);
    cyc = 0; got = 0; stall_ok = 1;
    while (!got && cyc < 100) begin
      @(posedge i_clk);
      @(negedge i_clk);
      cyc++;
      if (o_done === 1'b1) got = 1;
      else if (o_stall_req !== 1'b1 || o_busy !== 1'b1) stall_ok = 0;
    end
    chk({tag, ".latency"}, cyc, exp_lat(op, a, b));
    chk({tag, ".stall_busy"}, stall_ok, 1);
    chk({tag, ".stall_at_done"}, o_stall_req, 0);
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      if (got) begin
        chk({tag, ".result"}, o_result, e[31:0]);
        chk({tag, ".rd_out"}, o_rd_out, e[36:32]);
      end
    end
    $display("txn %s op=%0d a=%h b=%h result=%h rd_out=%0d cycles=%0d", tag, op, a, b, o_result, o_rd_out, cyc);
    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(negedge i_clk);
    chk({tag, ".done_once"}, o_done, 0);
    chk({tag, ".idle_after"}, o_busy, 0);
  endtask

  initial begin
    logic [31:0] prev;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;
    int n;

    i_nrst = 1'b0; i_start = 1'b0; i_op = '0; i_operand1 = '0; i_operand2 = '0; i_rd = '0; i_flush = 1'b0;
    #1;
    chk("reset.busy", o_busy, 0);
    chk("reset.done", o_done, 0);
    chk("reset.result", o_result, 0);
    chk("reset.rd_out", o_rd_out, 0);
    @(negedge i_clk);
    i_nrst = 1'b1;
    @(negedge i_clk);

    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd5,  32'h4000_0000);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF);
    run_op("div",    3'd4, -32'sd20,       32'd3,         5'd7,  32'hFFFF_FFFA);
    run_op("rem",    3'd6, -32'sd20,       32'd3,         5'd8,  32'hFFFF_FFFE);
    run_op("divu",   3'd5, 32'd100,        32'd7,         5'd9,  32'd14);
    run_op("remu",   3'd7, 32'd100,        32'd7,         5'd10, 32'd2);
    run_op("div0",   3'd4, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF);
    run_op("rem0",   3'd6, 32'd5,          32'd0,         5'd12, 32'd5);
    run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
    run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0);
    run_op("mulz",   3'd1, 32'h1234_5678,  32'd0,         5'd15, 32'd0);
    run_op("remneg0",3'd6, 32'hFFFF_FFFB,  32'd0,         5'd16, 32'hFFFF_FFFB);

    // Flush in CALC cycle 10: no done, result kept, next start accepted at once
    prev = o_result;
    i_op = 3'd0; i_operand1 = 32'd9; i_operand2 = 32'd9; i_rd = 5'd20; i_start = 1'b1;
    repeat (10) @(posedge i_clk);
    @(negedge i_clk);
    i_flush = 1'b1; i_start = 1'b0;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    @(negedge i_clk);
    chk("flush.busy", o_busy, 0);
    chk("flush.done", o_done, 0);
    chk("flush.result_kept", o_result, prev);
    chk("flush.stall", o_stall_req, 0);
    run_op("after_flush", 3'd5, 32'd1000, 32'd33, 5'd21, 32'd30);

    // Async reset in CALC cycle 5 with start still held
    i_op = 3'd5; i_operand1 = 32'd100; i_operand2 = 32'd7; i_rd = 5'd22; i_start = 1'b1;
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    i_nrst = 1'b0;
    #1;
    chk("arst.busy", o_busy, 0);
    chk("arst.stall", o_stall_req, 0);
    chk("arst.done", o_done, 0);
    chk("arst.result", o_result, 0);
    chk("arst.rd_out", o_rd_out, 0);
    i_start = 1'b0;
    @(negedge i_clk);
    i_nrst = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_done === 1'b1) n++;
    end
    chk("arst.no_done", n, 0);

    for (int k = 0; k < 8; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = (k == 2) ? 32'd0 : $urandom;
      rb  = (k == 5) ? 32'd0 : $urandom;
      if (k == 6) rb = 32'($urandom_range(1, 20));
      rrd = 5'($urandom_range(1, 31));
      run_op("rand", rop, ra, rb, rrd, model(rop, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
